branch_pred_unit: RTL and testbench
===================================

Name: branch_pred_unit

Overview:
- Parametrised successor to the single-cycle branch-condition logic, for the pipelined core.
- Combines three functions:
  - B-type condition evaluation in EX.
  - A PC-indexed branch history table (BHT) of saturating counters that gives taken/not-taken predictions to IF.
  - Registered resolution with mispredict detection, consumed by the hazard/flush logic one cycle later.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 64, number of counters; power of two, at least 2.
- CTR_BITS, 2, saturating counter width; at least 1.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  asynchronous, active-high reset.
- fetch_pc_i  input  XLEN  PC of the instruction in IF.
- pred_taken_o  output  1  combinational prediction for fetch_pc_i.
- ex_valid_i  input  1  EX stage holds a valid instruction.
- is_b_type_ctl_i  input  1  EX instruction is B-type.
- instr_func3_ctl_i  input  3  branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- ex_pc_i  input  XLEN  PC of the EX instruction.
- ex_pred_taken_i  input  1  prediction carried down the pipe with this instruction.
- opr_a_i  input  XLEN  source operand 1.
- opr_b_i  input  XLEN  source operand 2.
- flush_i  input  1  kill the EX instruction: no resolve, no table update.
- stall_i  input  1  EX held: registered outputs and table unchanged.
- res_valid_o  output  1  registered: a branch resolved last cycle.
- branch_taken_o  output  1  registered actual outcome.
- mispredict_o  output  1  registered: outcome differs from prediction.

Behaviour:
- Index: idx = PC[$clog2(BHT_ENTRIES)+1:2], for both fetch_pc_i and ex_pc_i.
- Prediction:
  - pred_taken_o = MSB of counter[idx(fetch_pc_i)]; purely combinational.
  - No bypass: a read of an entry in the same cycle it is written returns the pre-update value.
- Condition: cond = comparison selected by func3.
  - BEQ/BNE: equality.
  - BLT/BGE: signed XLEN compare.
  - BLTU/BGEU: unsigned XLEN compare.
  - func3 010/011 are illegal: cond = 0.
- Resolve qualifier: rv = ex_valid_i & is_b_type_ctl_i & ~flush_i & ~stall_i.
- Registered outputs, latency 1 cycle, updated on every posedge:
  - res_valid_o <= rv.
  - branch_taken_o <= rv & cond.
  - mispredict_o <= rv & (cond != ex_pred_taken_i).
  - Illegal func3 with ex_pred_taken_i = 1 reports a mispredict.
- Stall cycle: res_valid_o, branch_taken_o and mispredict_o all drop to 0 (rv = 0). The held instruction resolves on the cycle stall_i deasserts.
- Table update, same edge, when rv and func3 is legal:
  - Taken: counter[idx(ex_pc_i)] increments, saturating at all-ones.
  - Not taken: the counter decrements, saturating at 0.
  - No update on illegal func3, flush, stall or non-branch.
- Reset (async assert, sync deassert is the top-level's job):
  - All counters go to weakly-not-taken, 2^(CTR_BITS-1)-1; for CTR_BITS=1 that is 0.
  - res_valid_o, branch_taken_o and mispredict_o go to 0.
  - Reset mid-update discards the update.
- flush_i and stall_i together: flush wins, nothing resolves.
- Aliasing between PCs sharing an index is permitted and not detected.

Optional Feature:
- Macro: BRANCH_PRED_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs br_count_o (32) and mispred_count_o (32), both reset to 0.
  - br_count_o increments on every rv cycle; mispred_count_o increments on every rv cycle with a mispredict.
  - Both wrap modulo 2^32.
- Without the macro: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- riscv_pkg gains:
  - A branch_func3_e enum (BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111).
  - BHT_CTR_RESET as a function of CTR_BITS.
  - A br_resolve_t struct {valid, taken, mispredict}.
- Sub-module bht_table (parametrised by BHT_ENTRIES and CTR_BITS) holds:
  - The counter array.
  - The combinational read port.
  - The saturating write port.
- branch_pred_unit holds the comparator, resolve registers and optional counters.

Test Plan:
- Reset, then fetch_pc_i=0x100 -> pred_taken_o=0. Resolve BEQ at ex_pc=0x100 with a=b=5, pred=0 -> next cycle res_valid=1, taken=1, mispredict=1; counter 01->10; pred_taken_o for 0x100 now 1.
- BLT with a=0xFFFFFFFF, b=1 -> taken=1. BLTU with the same operands -> taken=0. BGEU with a=b=0 -> taken=1.
- Four consecutive taken resolves at 0x200 -> counter saturates at 11. Two not-taken resolves -> 01, pred=0.
- Resolve with flush_i=1, then with stall_i=1 -> res_valid=0 and the counter is unchanged. Deassert stall -> resolves on that cycle's edge.
- func3=010 with pred=1 -> mispredict=1, counter unchanged. Same-cycle fetch_pc=ex_pc=0x300 during update -> pred_taken_o shows the old value.
- With BRANCH_PRED_PERF_CNT_EN: 10 branches, 3 mispredicts -> br_count=10, mispred_count=3. Assert rst_i mid-stream -> both 0 and all counters back to 01.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: branch func3 encodings, resolve record, BHT reset value.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package riscv_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_func3_e;

  typedef struct packed {
    logic valid;
    logic taken;
    logic mispredict;
  } br_resolve_t;

  // Weakly-not-taken: 2^(ctr_bits-1)-1, which is 0 for a 1-bit counter.
  function automatic int unsigned bht_ctr_reset(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: array of saturating counters, one async read, one saturating write.
// Latency: read is combinational; write takes effect at the next clk edge (no read bypass).
// Backpressure: none; wr_en is simply ignored when low.
// Ports: clk/rst (async active-high), rd_idx -> rd_taken (counter MSB),
//        wr_en/wr_idx/wr_taken (increment on taken, decrement on not-taken).
module bht_table
  import riscv_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(bht_ctr_reset(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [CTR_BITS-1:0] ctr_q [BHT_ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr_q[i] <= CTR_RST;
      end
    end else if (wr_en) begin
      if (wr_taken) begin
        if (ctr_q[wr_idx] != CTR_MAX) ctr_q[wr_idx] <= ctr_q[wr_idx] + 1'b1;
      end else begin
        if (ctr_q[wr_idx] != '0) ctr_q[wr_idx] <= ctr_q[wr_idx] - 1'b1;
      end
    end
  end

  assign rd_taken = ctr_q[rd_idx][CTR_BITS-1];

endmodule

// File: rtl/branch_pred_unit.sv
// Branch condition evaluation, BHT prediction for IF and registered resolve/mispredict for hazard logic.
// Latency: pred_taken_o combinational; res_valid_o/branch_taken_o/mispredict_o 1 cycle after EX.
// Backpressure: stall_i holds EX (nothing resolves, table untouched); flush_i kills it and wins over stall.
// Ports: fetch_pc_i -> pred_taken_o; EX inputs (ex_valid_i, is_b_type_ctl_i, instr_func3_ctl_i,
//        ex_pc_i, ex_pred_taken_i, opr_a_i, opr_b_i, flush_i, stall_i) -> registered resolve outputs.
// Optional macro BRANCH_PRED_PERF_CNT_EN adds br_count_o / mispred_count_o (32-bit, wrapping).
module branch_pred_unit
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            pred_taken_o,
  input  logic            ex_valid_i,
  input  logic            is_b_type_ctl_i,
  input  logic [2:0]      instr_func3_ctl_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic            flush_i,
  input  logic            stall_i,
  output logic            res_valid_o,
  output logic            branch_taken_o,
  output logic            mispredict_o
`ifdef BRANCH_PRED_PERF_CNT_EN
  ,
  output logic [31:0]     br_count_o,
  output logic [31:0]     mispred_count_o
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic        cond;
  logic        func3_legal;
  logic        rv;
  br_resolve_t res_q;

  // Word-aligned PCs: drop the two low bits before indexing.
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  assign fetch_idx = fetch_pc_i[IDX_W+1:2];
  assign ex_idx    = ex_pc_i[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc_i[XLEN-1:IDX_W+2], fetch_pc_i[1:0],
                            ex_pc_i[XLEN-1:IDX_W+2], ex_pc_i[1:0]};

  always_comb begin
    cond = 1'b0;
    case (instr_func3_ctl_i)
      BEQ:     cond = (opr_a_i == opr_b_i);
      BNE:     cond = (opr_a_i != opr_b_i);
      BLT:     cond = ($signed(opr_a_i) <  $signed(opr_b_i));
      BGE:     cond = ($signed(opr_a_i) >= $signed(opr_b_i));
      BLTU:    cond = (opr_a_i <  opr_b_i);
      BGEU:    cond = (opr_a_i >= opr_b_i);
      default: cond = 1'b0;
    endcase
  end

  // 010/011 are the only non-branch encodings; they still resolve (and can mispredict) but never train.
  assign func3_legal = (instr_func3_ctl_i[2:1] != 2'b01);
  assign rv = ex_valid_i & is_b_type_ctl_i & ~flush_i & ~stall_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q <= '0;
    end else begin
      res_q.valid      <= rv;
      res_q.taken      <= rv & cond;
      res_q.mispredict <= rv & (cond != ex_pred_taken_i);
    end
  end

  assign res_valid_o    = res_q.valid;
  assign branch_taken_o = res_q.taken;
  assign mispredict_o   = res_q.mispredict;

  bht_table #(
    .BHT_ENTRIES(BHT_ENTRIES),
    .CTR_BITS   (CTR_BITS)
  ) u_bht (
    .clk     (clk_i),
    .rst     (rst_i),
    .rd_idx  (fetch_idx),
    .rd_taken(pred_taken_o),
    .wr_en   (rv & func3_legal),
    .wr_idx  (ex_idx),
    .wr_taken(cond)
  );

`ifdef BRANCH_PRED_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_count_o      <= '0;
      mispred_count_o <= '0;
    end else if (rv) begin
      br_count_o <= br_count_o + 32'd1;
      if (cond != ex_pred_taken_i) mispred_count_o <= mispred_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pred_unit.sv
// Bench for branch_pred_unit: vector table plus reset / perf-counter sequences.
// Latency: checks registered outputs one edge after drive, prediction before the edge.
// Backpressure: exercises stall, flush and their combination.
module tb_branch_pred_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] fetch_pc_i;
  logic        pred_taken_o;
  logic        ex_valid_i;
  logic        is_b_type_ctl_i;
  logic [2:0]  instr_func3_ctl_i;
  logic [31:0] ex_pc_i;
  logic        ex_pred_taken_i;
  logic [31:0] opr_a_i;
  logic [31:0] opr_b_i;
  logic        flush_i;
  logic        stall_i;
  logic        res_valid_o;
  logic        branch_taken_o;
  logic        mispredict_o;
`ifdef BRANCH_PRED_PERF_CNT_EN
  logic [31:0] br_count_o;
  logic [31:0] mispred_count_o;
`endif

  always #5 clk_i = ~clk_i;

  branch_pred_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .fetch_pc_i       (fetch_pc_i),
    .pred_taken_o     (pred_taken_o),
    .ex_valid_i       (ex_valid_i),
    .is_b_type_ctl_i  (is_b_type_ctl_i),
    .instr_func3_ctl_i(instr_func3_ctl_i),
    .ex_pc_i          (ex_pc_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .opr_a_i          (opr_a_i),
    .opr_b_i          (opr_b_i),
    .flush_i          (flush_i),
    .stall_i          (stall_i),
    .res_valid_o      (res_valid_o),
    .branch_taken_o   (branch_taken_o),
    .mispredict_o     (mispredict_o)
`ifdef BRANCH_PRED_PERF_CNT_EN
    ,
    .br_count_o       (br_count_o),
    .mispred_count_o  (mispred_count_o)
`endif
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic        vld;
    logic        bt;
    logic        fl;
    logic        st;
    logic        e_vld;
    logic        e_tk;
    logic        e_mis;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int mdl_ctr [64];
  logic [2:0] sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pidx(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic logic mdl_pred(input logic [31:0] pc);
    return (mdl_ctr[pidx(pc)] >= 2);
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 64; i++) mdl_ctr[i] = 1;
  endtask

  task automatic drive_idle();
    ex_valid_i = 1'b0; is_b_type_ctl_i = 1'b0; instr_func3_ctl_i = 3'b000;
    ex_pc_i = 32'h0; ex_pred_taken_i = 1'b0; opr_a_i = 32'h0; opr_b_i = 32'h0;
    flush_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string name);
    logic [2:0] exp;
    @(negedge clk_i);
    fetch_pc_i = v.pc; ex_pc_i = v.pc; instr_func3_ctl_i = v.f3;
    opr_a_i = v.a; opr_b_i = v.b; ex_pred_taken_i = v.pred;
    ex_valid_i = v.vld; is_b_type_ctl_i = v.bt; flush_i = v.fl; stall_i = v.st;
    #1;
    chk({name, " pred"}, 32'(pred_taken_o), 32'(mdl_pred(v.pc)));
    sb_q.push_back({v.e_vld, v.e_tk, v.e_mis});
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      chk({name, " scoreboard"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      chk({name, " res_valid"}, 32'(res_valid_o), 32'(exp[2]));
      chk({name, " taken"}, 32'(branch_taken_o), 32'(exp[1]));
      chk({name, " mispredict"}, 32'(mispredict_o), 32'(exp[0]));
    end
    if (v.e_vld && (v.f3[2:1] != 2'b01)) begin
      if (v.e_tk && mdl_ctr[pidx(v.pc)] < 3) mdl_ctr[pidx(v.pc)]++;
      if (!v.e_tk && mdl_ctr[pidx(v.pc)] > 0) mdl_ctr[pidx(v.pc)]--;
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] a,
                              input logic [31:0] b, input logic pred, input logic vld, input logic bt,
                              input logic fl, input logic st, input logic e_vld, input logic e_tk,
                              input logic e_mis);
    vec_t v;
    v.f3 = f3; v.pc = pc; v.a = a; v.b = b; v.pred = pred; v.vld = vld; v.bt = bt;
    v.fl = fl; v.st = st; v.e_vld = e_vld; v.e_tk = e_tk; v.e_mis = e_mis;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    rst_i = 1'b1;
    fetch_pc_i = 32'h100;
    drive_idle();
    mdl_reset();

    //           f3      pc      a            b            pd v  bt fl st  ev et em
    tbl.push_back(mk(3'b000, 32'h100, 32'd5,        32'd5,        0, 1, 1, 0, 0, 1, 1, 1)); // BEQ taken, mispredict
    tbl.push_back(mk(3'b000, 32'h100, 32'd0,        32'd0,        0, 0, 0, 0, 0, 0, 0, 0)); // idle, pred now 1
    tbl.push_back(mk(3'b100, 32'h104, 32'hFFFFFFFF, 32'd1,        0, 1, 1, 0, 0, 1, 1, 1)); // BLT -1 < 1
    tbl.push_back(mk(3'b110, 32'h108, 32'hFFFFFFFF, 32'd1,        0, 1, 1, 0, 0, 1, 0, 0)); // BLTU max < 1 false
    tbl.push_back(mk(3'b111, 32'h10C, 32'd0,        32'd0,        1, 1, 1, 0, 0, 1, 1, 0)); // BGEU 0 >= 0
    tbl.push_back(mk(3'b001, 32'h110, 32'd3,        32'd4,        1, 1, 1, 0, 0, 1, 1, 0)); // BNE taken
    tbl.push_back(mk(3'b101, 32'h114, 32'd1,        32'hFFFFFFFF, 0, 1, 1, 0, 0, 1, 1, 1)); // BGE 1 >= -1
    tbl.push_back(mk(3'b101, 32'h118, 32'h80000000, 32'd0,        1, 1, 1, 0, 0, 1, 0, 1)); // BGE min >= 0 false
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(3'b000, 32'h200, 32'd7, 32'd7, 0, 1, 1, 0, 0, 1, 1, 1));         // saturate up
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(3'b001, 32'h200, 32'd7, 32'd7, 1, 1, 1, 0, 0, 1, 0, 1));         // 11 -> 10 -> 01
    tbl.push_back(mk(3'b000, 32'h200, 32'd0,        32'd0,        0, 0, 0, 0, 0, 0, 0, 0)); // pred back to 0
    tbl.push_back(mk(3'b000, 32'h204, 32'd9,        32'd9,        0, 1, 1, 1, 0, 0, 0, 0)); // flush
    tbl.push_back(mk(3'b000, 32'h204, 32'd9,        32'd9,        0, 1, 1, 0, 1, 0, 0, 0)); // stall
    tbl.push_back(mk(3'b000, 32'h204, 32'd9,        32'd9,        0, 1, 1, 1, 1, 0, 0, 0)); // flush+stall
    tbl.push_back(mk(3'b000, 32'h204, 32'd9,        32'd9,        0, 1, 1, 0, 0, 1, 1, 1)); // stall released
    tbl.push_back(mk(3'b000, 32'h204, 32'd0,        32'd0,        0, 0, 0, 0, 0, 0, 0, 0)); // pred now 1
    tbl.push_back(mk(3'b000, 32'h208, 32'd1,        32'd1,        0, 1, 0, 0, 0, 0, 0, 0)); // non-branch
    tbl.push_back(mk(3'b000, 32'h20C, 32'd1,        32'd1,        0, 0, 1, 0, 0, 0, 0, 0)); // invalid EX
    tbl.push_back(mk(3'b010, 32'h300, 32'd1,        32'd1,        1, 1, 1, 0, 0, 1, 0, 1)); // illegal, pred 1
    tbl.push_back(mk(3'b011, 32'h300, 32'd1,        32'd1,        0, 1, 1, 0, 0, 1, 0, 0)); // illegal, pred 0
    tbl.push_back(mk(3'b000, 32'h300, 32'd2,        32'd2,        0, 1, 1, 0, 0, 1, 1, 1)); // same-cycle read old
    tbl.push_back(mk(3'b000, 32'h300, 32'd0,        32'd0,        0, 0, 0, 0, 0, 0, 0, 0)); // pred now 1

    repeat (2) @(negedge clk_i);
    #1;
    chk("reset res_valid", 32'(res_valid_o), 32'd0);
    chk("reset taken", 32'(branch_taken_o), 32'd0);
    chk("reset mispredict", 32'(mispredict_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    fetch_pc_i = 32'h3FC;
    #1;
    chk("reset pred 0x3FC", 32'(pred_taken_o), 32'd0);
`ifdef BRANCH_PRED_PERF_CNT_EN
    chk("reset br_count", br_count_o, 32'd0);
    chk("reset mispred_count", mispred_count_o, 32'd0);
`endif

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted over an update edge: the update is dropped and the table reverts.
    @(negedge clk_i);
    drive_idle();
    fetch_pc_i = 32'h100; ex_pc_i = 32'h100; instr_func3_ctl_i = 3'b000;
    opr_a_i = 32'd4; opr_b_i = 32'd4; ex_valid_i = 1'b1; is_b_type_ctl_i = 1'b1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst res_valid", 32'(res_valid_o), 32'd0);
    chk("midrst taken", 32'(branch_taken_o), 32'd0);
    chk("midrst mispredict", 32'(mispredict_o), 32'd0);
    @(negedge clk_i);
    drive_idle();
    rst_i = 1'b0;
    mdl_reset();
    #1;
    chk("midrst pred 0x100", 32'(pred_taken_o), 32'd0);
    fetch_pc_i = 32'h300;
    #1;
    chk("midrst pred 0x300", 32'(pred_taken_o), 32'd0);
`ifdef BRANCH_PRED_PERF_CNT_EN
    chk("midrst br_count", br_count_o, 32'd0);
    chk("midrst mispred_count", mispred_count_o, 32'd0);
`endif
    apply(mk(3'b000, 32'h400, 32'd1, 32'd1, 1, 1, 1, 0, 0, 1, 1, 0), "post-rst beq");
    apply(mk(3'b000, 32'h400, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0), "post-rst idle");

`ifdef BRANCH_PRED_PERF_CNT_EN
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    mdl_reset();
    for (int i = 0; i < 10; i++) begin
      v = mk(3'b000, 32'h500, 32'd6, 32'd6, (i >= 3), 1, 1, 0, 0, 1, 1, (i < 3));
      apply(v, $sformatf("perf%0d", i));
    end
    apply(mk(3'b000, 32'h504, 32'd6, 32'd6, 0, 1, 1, 0, 1, 0, 0, 0), "perf stalled");
    chk("perf br_count", br_count_o, 32'd10);
    chk("perf mispred_count", mispred_count_o, 32'd3);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("perf rst br_count", br_count_o, 32'd0);
    chk("perf rst mispred_count", mispred_count_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    mdl_reset();
    fetch_pc_i = 32'h500;
    #1;
    chk("perf rst pred 0x500", 32'(pred_taken_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
